// File: rtl/fp16_sub_seq.sv
// Multi-cycle fp16 subtractor y = a - b: one alignment shift and one normalisation
// step per cycle, truncating alignment, valid/ready handshake on both sides.
module fp16_sub_seq #(
   parameter logic [15:0] CANON_NAN = 16'h7E00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] y,
   output logic        busy
);

   // state  | meaning
   // IDLE   | waiting for operands, special cases resolved on accept
   // ALIGN  | smaller-exponent significand shifts right one bit per cycle
   // OP     | magnitude add or subtract, result overwrites ma/sa
   // NORM   | one normalising shift per cycle, then pack
   // DONE   | y held until out_ready
   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_OP, S_NORM, S_DONE} state_t;

   state_t      state_q, state_d;
   logic        sa_q, sa_d, sb_q, sb_d;
   logic [11:0] ma_q, ma_d, mb_q, mb_d;
   logic [5:0]  exp_q, exp_d;
   logic [4:0]  diff_q, diff_d;
   logic        shift_b_q, shift_b_d;
   logic [15:0] y_q, y_d;
   logic        out_valid_q, out_valid_d;

   logic [4:0]  ea_raw, eb_raw, ea_eff, eb_eff;
   logic [11:0] sig_a, sig_b;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_special;
   logic [15:0] special_y, packed_y;

   assign ea_raw = a[14:10];
   assign eb_raw = b[14:10];
   assign ea_eff = (ea_raw == 5'd0) ? 5'd1 : ea_raw;
   assign eb_eff = (eb_raw == 5'd0) ? 5'd1 : eb_raw;
   assign sig_a  = {1'b0, ea_raw != 5'd0, a[9:0]};
   assign sig_b  = {1'b0, eb_raw != 5'd0, b[9:0]};
   assign a_nan  = (ea_raw == 5'h1F) && (a[9:0] != 10'd0);
   assign b_nan  = (eb_raw == 5'h1F) && (b[9:0] != 10'd0);
   assign a_inf  = (ea_raw == 5'h1F) && (a[9:0] == 10'd0);
   assign b_inf  = (eb_raw == 5'h1F) && (b[9:0] == 10'd0);
   assign a_zero = (a[14:0] == 15'd0);
   assign b_zero = (b[14:0] == 15'd0);
   assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

   always_comb begin
      special_y = a;
      if (a_nan || b_nan) begin
         special_y = CANON_NAN;
      end else if (a_inf && b_inf && (a[15] == b[15])) begin
         special_y = CANON_NAN;
      end else if (a_inf) begin
         special_y = a;
      end else if (b_inf) begin
         special_y = {~b[15], b[14:0]};
      end else if (a_zero && b_zero) begin
         special_y = {a[15] & ~b[15], 15'd0};
      end else if (a_zero) begin
         special_y = {~b[15], b[14:0]};
      end
   end

   // A hidden bit still clear at pack time can only mean exponent 1, i.e. subnormal.
   always_comb begin
      if (ma_q == 12'd0) begin
         packed_y = 16'h0000;
      end else if (exp_q >= 6'd31) begin
         packed_y = {sa_q, 5'h1F, 10'd0};
      end else if (!ma_q[10]) begin
         packed_y = {sa_q, 5'h00, ma_q[9:0]};
      end else begin
         packed_y = {sa_q, exp_q[4:0], ma_q[9:0]};
      end
   end

   always_comb begin
      state_d     = state_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      ma_d        = ma_q;
      mb_d        = mb_q;
      exp_d       = exp_q;
      diff_d      = diff_q;
      shift_b_d   = shift_b_q;
      y_d         = y_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sa_d = a[15];
               sb_d = ~b[15];
               ma_d = sig_a;
               mb_d = sig_b;
               if (ea_eff >= eb_eff) begin
                  exp_d     = {1'b0, ea_eff};
                  diff_d    = ea_eff - eb_eff;
                  shift_b_d = 1'b1;
               end else begin
                  exp_d     = {1'b0, eb_eff};
                  diff_d    = eb_eff - ea_eff;
                  shift_b_d = 1'b0;
               end
               if (is_special) begin
                  y_d         = special_y;
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end else if (ea_eff != eb_eff) begin
                  state_d = S_ALIGN;
               end else begin
                  state_d = S_OP;
               end
            end
         end
         S_ALIGN: begin
            if (diff_q >= 5'd12) begin
               if (shift_b_q) mb_d = 12'd0;
               else           ma_d = 12'd0;
               diff_d  = 5'd0;
               state_d = S_OP;
            end else begin
               if (shift_b_q) mb_d = mb_q >> 1;
               else           ma_d = ma_q >> 1;
               diff_d = diff_q - 5'd1;
               if (diff_q == 5'd1) state_d = S_OP;
            end
         end
         S_OP: begin
            if (sa_q == sb_q) begin
               ma_d = ma_q + mb_q;
            end else if (ma_q > mb_q) begin
               ma_d = ma_q - mb_q;
            end else if (mb_q > ma_q) begin
               ma_d = mb_q - ma_q;
               sa_d = sb_q;
            end else begin
               ma_d = 12'd0;
               sa_d = 1'b0;
            end
            state_d = S_NORM;
         end
         S_NORM: begin
            if (ma_q[11]) begin
               ma_d  = ma_q >> 1;
               exp_d = exp_q + 6'd1;
            end else if (!ma_q[10] && (ma_q != 12'd0) && (exp_q > 6'd1)) begin
               ma_d  = ma_q << 1;
               exp_d = exp_q - 6'd1;
            end else begin
               y_d         = packed_y;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sa_q        <= 1'b0;
         sb_q        <= 1'b0;
         ma_q        <= 12'd0;
         mb_q        <= 12'd0;
         exp_q       <= 6'd0;
         diff_q      <= 5'd0;
         shift_b_q   <= 1'b0;
         y_q         <= 16'h0000;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         ma_q        <= ma_d;
         mb_q        <= mb_d;
         exp_q       <= exp_d;
         diff_q      <= diff_d;
         shift_b_q   <= shift_b_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign y         = y_q;

endmodule

// File: tb/tb_fp16_sub_seq.sv
// Self-checking bench for fp16_sub_seq: directed table, randomized ops against an
// arithmetic reference model, DONE back-pressure and mid-operation reset.
module tb_fp16_sub_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = 16'h0;
   logic [15:0] b = 16'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] y;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Latency is counted in rising edges after the accept edge; special cases
   // reach DONE on the accept edge itself and are ready in the following cycle.
   localparam int SPECIAL_LAT = 0;

   fp16_sub_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .y        (y),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   function automatic int abs_i(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Value model: significand * 2^(exp-25); alignment truncates, then integer
   // sum, then normalise to the [1024,2048) window or stop at exponent 1.
   function automatic void ref_sub(input logic [15:0] ra, input logic [15:0] rb,
                                   output logic [15:0] ry, output int lat);
      int ea, eb, xa, xb, d, e, r, m, k, al;
      logic s;
      bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      ea = int'(ra[14:10]);
      eb = int'(rb[14:10]);
      a_nan  = (ea == 31) && (ra[9:0] != 0);
      b_nan  = (eb == 31) && (rb[9:0] != 0);
      a_inf  = (ea == 31) && (ra[9:0] == 0);
      b_inf  = (eb == 31) && (rb[9:0] == 0);
      a_zero = (ra[14:0] == 0);
      b_zero = (rb[14:0] == 0);
      lat = SPECIAL_LAT;
      if (a_nan || b_nan)                          ry = 16'h7E00;
      else if (a_inf && b_inf && ra[15] == rb[15]) ry = 16'h7E00;
      else if (a_inf)                              ry = ra;
      else if (b_inf)                              ry = rb ^ 16'h8000;
      else if (a_zero && b_zero)                   ry = {ra[15] & ~rb[15], 15'd0};
      else if (a_zero)                             ry = rb ^ 16'h8000;
      else if (b_zero)                             ry = ra;
      else begin
         xa = int'(ra[9:0]) + ((ea == 0) ? 0 : 1024);
         xb = int'(rb[9:0]) + ((eb == 0) ? 0 : 1024);
         if (ea == 0) ea = 1;
         if (eb == 0) eb = 1;
         d = abs_i(ea - eb);
         e = (ea >= eb) ? ea : eb;
         if (ea >= eb) xb = (d >= 12) ? 0 : (xb >> d);
         else          xa = (d >= 12) ? 0 : (xa >> d);
         al = (d == 0) ? 0 : ((d >= 12) ? 1 : d);
         r = (ra[15] ? -xa : xa) + (rb[15] ? xb : -xb);
         s = (r < 0);
         m = abs_i(r);
         k = 0;
         if (m >= 2048) begin
            m = m / 2;
            e = e + 1;
            k = k + 1;
         end
         while (m != 0 && m < 1024 && e > 1) begin
            m = m * 2;
            e = e - 1;
            k = k + 1;
         end
         if (m == 0)        ry = 16'h0000;
         else if (e >= 31)  ry = {s, 5'h1F, 10'd0};
         else if (m < 1024) ry = {s, 5'd0, m[9:0]};
         else               ry = {s, e[4:0], m[9:0]};
         lat = 2 + al + k;
      end
   endfunction

   // Accept one operation, wait (bounded) for out_valid, optionally leave it unacknowledged.
   task automatic launch(input logic [15:0] ta, input logic [15:0] tb_v,
                         output logic [15:0] ry, output int lat, output bit tmo);
      @(negedge clk);
      a = ta;
      b = tb_v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      lat = 0;
      tmo = 1'b0;
      while (!out_valid && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) tmo = 1'b1;
      ry = y;
   endtask

   task automatic drain();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic run_check(input string name, input logic [15:0] ta, input logic [15:0] tb_v,
                            input logic [15:0] exp_y, input int exp_lat);
      logic [15:0] ry;
      int          lat;
      bit          tmo;
      launch(ta, tb_v, ry, lat, tmo);
      check({name, "_timeout"}, int'(tmo), 0);
      check({name, "_y"}, int'(ry), int'(exp_y));
      check({name, "_lat"}, lat, exp_lat);
      drain();
      check({name, "_in_ready_after"}, int'(in_ready), 1);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] y;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [15:0] ry, hold_y, ra, rb, ey;
      int          lat, elat;
      bit          tmo;

      vecs[0]  = '{16'h4200, 16'h3C00, 16'h4000, 3};
      vecs[1]  = '{16'h3C00, 16'hBC00, 16'h4000, 3};
      vecs[2]  = '{16'h3C01, 16'h3C00, 16'h1400, 12};
      vecs[3]  = '{16'h3C00, 16'h3C00, 16'h0000, 2};
      vecs[4]  = '{16'h6400, 16'h1400, 16'h6400, 3};
      vecs[5]  = '{16'h7BFF, 16'hFBFF, 16'h7C00, 3};
      vecs[6]  = '{16'h7C00, 16'h7C00, 16'h7E00, SPECIAL_LAT};
      vecs[7]  = '{16'h7C01, 16'h1234, 16'h7E00, SPECIAL_LAT};
      vecs[8]  = '{16'h8000, 16'h0000, 16'h8000, SPECIAL_LAT};
      vecs[9]  = '{16'h0000, 16'h3C00, 16'hBC00, SPECIAL_LAT};
      vecs[10] = '{16'hFC00, 16'h7C00, 16'hFC00, SPECIAL_LAT};

      #12;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_y", int'(y), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_in_ready", int'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].lat);
      end

      // Back-pressure: result must sit still in DONE.
      launch(16'h4200, 16'h3C00, hold_y, lat, tmo);
      check("hold_timeout", int'(tmo), 0);
      check("hold_first_y", int'(hold_y), 16'h4000);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("hold_y_c%0d", c), int'(y), int'(hold_y));
         check($sformatf("hold_valid_c%0d", c), int'(out_valid), 1);
         check($sformatf("hold_in_ready_c%0d", c), int'(in_ready), 0);
      end
      drain();

      // Reset during a long alignment (d=11).
      @(negedge clk);
      a = 16'h4200;
      b = 16'h1400;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("align_busy_before_rst", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      check("midrst_busy", int'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      ref_sub(16'h4200, 16'h3C00, ey, elat);
      run_check("after_rst", 16'h4200, 16'h3C00, ey, elat);

      // Randomized operands, exponents biased so both close and distant alignments occur.
      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 3) != 0)
            rb[14:10] = 5'(($urandom_range(0, 1) != 0) ? ra[14:10] - 5'($urandom_range(0, 3))
                                                       : ra[14:10] + 5'($urandom_range(0, 3)));
         if ($urandom_range(0, 15) == 0) rb[14:10] = 5'd0;
         ref_sub(ra, rb, ey, elat);
         launch(ra, rb, ry, lat, tmo);
         if (tmo) check($sformatf("rand%0d_timeout a=%h b=%h", i, ra, rb), 1, 0);
         else begin
            check($sformatf("rand%0d_y a=%h b=%h", i, ra, rb), int'(ry), int'(ey));
            check($sformatf("rand%0d_lat a=%h b=%h", i, ra, rb), lat, elat);
         end
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
